// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encodings and sizing helpers for the multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MDOP_MULT  = 2'd0,
        MDOP_MULTU = 2'd1,
        MDOP_DIV   = 2'd2,
        MDOP_DIVU  = 2'd3
    } mdop_e;

    typedef enum logic [1:0] {
        MDST_IDLE = 2'd0,
        MDST_RUN  = 2'd1,
        MDST_FIX  = 2'd2,
        MDST_DONE = 2'd3
    } mdst_e;

    localparam int MD_CNT_MIN_W = 6;

    // Iteration counter width: enough for WIDTH steps, never narrower than 6 bits.
    function automatic int md_cnt_w(input int width);
        int w;
        w = $clog2(width + 1);
        return (w < MD_CNT_MIN_W) ? MD_CNT_MIN_W : w;
    endfunction

    function automatic logic md_is_div(input mdop_e op);
        return op[1];
    endfunction

    // MULT and DIV are the signed flavours (even codes).
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// acc holds {upper, lower}: product accumulator, or {remainder, dividend/quotient}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] upper;
    logic [WIDTH:0] trial;

    // Single-step datapath on WIDTH+1 bits; the extra bit is the carry / borrow.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b};
        upper = acc[2*WIDTH-1:WIDTH-1];
        trial = upper - {1'b0, b};
        if (is_div) begin
            if (trial[WIDTH])
                acc_nxt = {upper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else if (acc[0]) begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
// Operates on magnitudes; the sign correction is applied in a single FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int             CW   = md_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mdst_e              state_q, state_d;
    mdop_e              op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               idle_like, accept, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] step_acc, prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (md_is_div(op_q)),
        .acc     (acc_q),
        .b       (b_q),
        .acc_nxt (step_acc)
    );

    // Request acceptance: only when not busy, and flush always wins.
    always_comb begin
        idle_like = (state_q == MDST_IDLE) || (state_q == MDST_DONE);
        accept    = idle_like && start && !flush;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDST_IDLE: if (accept) state_d = MDST_RUN;
            MDST_RUN:  if (flush) state_d = MDST_IDLE;
                       else if (cnt_q == LAST) state_d = MDST_FIX;
            MDST_FIX:  state_d = flush ? MDST_IDLE : MDST_DONE;
            MDST_DONE: state_d = accept ? MDST_RUN : MDST_IDLE;
            default:   state_d = MDST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix and HI/LO update.
    always_comb begin
        op_d      = op_q;
        acc_d     = acc_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        a_neg = md_is_signed(op) && a[WIDTH-1];
        b_neg = md_is_signed(op) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            MDST_IDLE, MDST_DONE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (accept) begin
                    op_d      = mdop_e'(op);
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d       = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                end
            end
            MDST_RUN: begin
                if (!flush) begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MDST_FIX: begin
                if (!flush) begin
                    if (md_is_div(op_q)) begin
                        hi_d  = rem_fix;
                        lo_d  = quo_fix;
                        dbz_d = (b_q == '0);
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDST_IDLE;
            op_q      <= MDOP_MULT;
            acc_q     <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == MDST_RUN) || (state_q == MDST_FIX);
    assign done        = (state_q == MDST_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until done is seen; bounded.
    task automatic wait_done(output int cycles, output int busy_cycles, output bit ok);
        cycles = 1; busy_cycles = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (busy) busy_cycles++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_multu();
        int cyc, bcyc; bit ok;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok || cyc != 34) begin n_err++; $display("FAIL multu_latency got %0d want 34", cyc); end
        n_cmp++; if (bcyc != 33) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 33", bcyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_done_busy got %b want 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult();
        int cyc, bcyc; bit ok;
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mult_timeout got %0d cycles want done", cyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc; bit ok;
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL div_timeout got %0d cycles want done", cyc); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", hi); end
        // start sampled during the DONE cycle
        issue(2'd3, 32'd100, 32'd7);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got %b want 0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok || cyc != 34) begin n_err++; $display("FAIL b2b_latency got %0d want 34", cyc); end
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL b2b_lo got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_hi got %h want 00000002", hi); end
    endtask

    task automatic test_div_zero();
        int cyc, bcyc; bit ok;
        issue(2'd3, 32'd5, 32'd0);
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok || cyc != 34) begin n_err++; $display("FAIL dbz_latency got %0d want 34", cyc); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'd5) begin n_err++; $display("FAIL dbz_hi got %h want 00000005", hi); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
        tick();
        issue(2'd1, 32'd2, 32'd3);
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok || lo !== 32'd6 || hi !== 32'd0) begin n_err++; $display("FAIL multu_small got %h_%h want 00000000_00000006", hi, lo); end
    endtask

    task automatic test_overflow();
        int cyc, bcyc; bit ok;
        tick();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bcyc, ok);
        n_cmp++; if (!ok || lo !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL ovf_hi got %h want 00000000", hi); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL ovf_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_wr();
        tick();
        wr_hi = 1'b1; wdata = 32'h11; tick(); wr_hi = 1'b0;
        wr_lo = 1'b1; wdata = 32'h22; tick(); wr_lo = 1'b0;
        n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL wr_hi got %h want 00000011", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL wr_lo got %h want 00000022", lo); end
    endtask

    task automatic test_flush();
        int ndone;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // now in RUN cycle 1
        tick(); tick();                              // RUN cycle 3
        start = 1'b1; op = 2'd3; a = 32'd1; b = 32'd1;
        wr_lo = 1'b1; wdata = 32'h99;
        tick();                                      // RUN cycle 4
        start = 1'b0; wr_lo = 1'b0;
        n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL busy_wr_lo got %h want 00000022", lo); end
        repeat (6) tick();                           // RUN cycle 10
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
        ndone = 0;
        repeat (50) begin if (done) ndone++; tick(); end
        n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL flush_no_done got %0d want 0", ndone); end
        n_cmp++; if (hi !== 32'h11 || lo !== 32'h22) begin n_err++; $display("FAIL flush_hilo got %h_%h want 00000011_00000022", hi, lo); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // RUN cycle 1
        repeat (19) tick();                          // RUN cycle 20
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctl got busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hi, lo); end
        ndone = 0;
        repeat (50) begin if (done) ndone++; tick(); end
        n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", ndone); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'd0; a = '0; b = '0; wdata = '0;
        test_reset();
        test_multu();
        test_mult();
        test_back_to_back();
        test_div_zero();
        test_overflow();
        test_wr();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
